// File: rtl/local_injection_scheduler_pkg.sv
// Shared NoC parameters and flit types, plus injection-scheduler state and head-flit packing.
// Consumers of LOCAL_INJ_STATS_EN see no difference here; the package is configuration-independent.
package noc_params;

    localparam int VC_NUM           = 2;
    localparam int VC_SIZE          = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
    localparam int FLIT_DATA_SIZE   = 16;
    localparam int DEST_ADDR_SIZE_X = 2;
    localparam int DEST_ADDR_SIZE_Y = 2;
    localparam int HEAD_PL_SIZE     = FLIT_DATA_SIZE - DEST_ADDR_SIZE_X - DEST_ADDR_SIZE_Y;
    localparam int DEF_MAX_PKT_LEN  = 8;

    typedef enum logic [1:0] {
        HEAD     = 2'b00,
        BODY     = 2'b01,
        TAIL     = 2'b10,
        HEADTAIL = 2'b11
    } flit_label_t;

    typedef struct packed {
        flit_label_t                flit_label;
        logic [VC_SIZE-1:0]         vc_id;
        logic [FLIT_DATA_SIZE-1:0]  data;
    } flit_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } inj_state_t;

    // Head flits carry the destination in the top bits of the data field.
    function automatic flit_t pack_head_flit(
        input flit_label_t                 label,
        input logic [VC_SIZE-1:0]          vc,
        input logic [DEST_ADDR_SIZE_X-1:0] x_dest,
        input logic [DEST_ADDR_SIZE_Y-1:0] y_dest,
        input logic [HEAD_PL_SIZE-1:0]     pl
    );
        flit_t f;
        f.flit_label = label;
        f.vc_id      = vc;
        f.data       = {x_dest, y_dest, pl};
        return f;
    endfunction

endpackage

// File: rtl/local_injection_scheduler_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr_i, wrapping to index 0.
module inj_rr_arbiter #(
    parameter  int SRC_NUM = 4,
    localparam int PTR_W   = (SRC_NUM > 1) ? $clog2(SRC_NUM) : 1
) (
    input  logic [SRC_NUM-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [SRC_NUM-1:0] grant_o,
    output logic [PTR_W-1:0]   grant_idx_o,
    output logic               valid_o
);

    always_comb begin
        int unsigned idx;
        idx         = 0;
        grant_o     = '0;
        grant_idx_o = '0;
        valid_o     = 1'b0;
        for (int unsigned off = 0; off < SRC_NUM; off++) begin
            idx = (32'(ptr_i) + off) % SRC_NUM;
            if (!valid_o && req_i[idx]) begin
                valid_o      = 1'b1;
                grant_o[idx] = 1'b1;
                grant_idx_o  = PTR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/local_injection_scheduler.sv
// Shares one local injection port among SRC_NUM sources: RR pick, VC allocation, flit sequencing.
// Define LOCAL_INJ_STATS_EN to add pkt_cnt_o (per-source saturating count of packets completed).
module local_injection_scheduler
    import noc_params::*;
#(
    parameter  int SRC_NUM     = 4,
    parameter  int MAX_PKT_LEN = DEF_MAX_PKT_LEN,
    parameter  int MESH_SIZE_X = 2,
    parameter  int MESH_SIZE_Y = 3,
    localparam int LEN_W       = $clog2(MAX_PKT_LEN + 1),
    localparam int PTR_W       = (SRC_NUM > 1) ? $clog2(SRC_NUM) : 1
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [SRC_NUM-1:0]                         src_req_i,
    input  logic [SRC_NUM-1:0][DEST_ADDR_SIZE_X-1:0]   src_x_dest_i,
    input  logic [SRC_NUM-1:0][DEST_ADDR_SIZE_Y-1:0]   src_y_dest_i,
    input  logic [SRC_NUM-1:0][LEN_W-1:0]              src_len_i,
    input  logic [SRC_NUM-1:0][FLIT_DATA_SIZE-1:0]     src_data_i,
    output logic [SRC_NUM-1:0]                         src_ack_o,
    output flit_t                                      data_o,
    output logic                                       is_valid_o,
    input  logic [VC_NUM-1:0]                          is_on_off_i,
    input  logic [VC_NUM-1:0]                          is_allocatable_i,
    output logic                                       busy_o,
    output logic                                       err_o
`ifdef LOCAL_INJ_STATS_EN
    ,
    output logic [SRC_NUM-1:0][15:0]                   pkt_cnt_o
`endif
);

    inj_state_t          state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [PTR_W-1:0]    src_q, src_d;
    logic [VC_SIZE-1:0]  vc_q, vc_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    flit_t               data_q, data_d;
    logic                valid_q, valid_d;
    logic                busy_q, busy_d;
    logic                err_q, err_d;

    logic [SRC_NUM-1:0]  arb_grant;
    logic [PTR_W-1:0]    arb_idx;
    logic                arb_valid;
    logic [SRC_NUM-1:0]  ack;

    logic [LEN_W-1:0]            w_len;
    logic [DEST_ADDR_SIZE_X-1:0] w_x;
    logic [DEST_ADDR_SIZE_Y-1:0] w_y;
    logic                        w_legal;
    logic [PTR_W-1:0]            ptr_next;
    logic [VC_NUM-1:0]           vc_avail;
    logic                        vc_found;
    logic [VC_SIZE-1:0]          vc_sel;
    flit_label_t                 head_lbl;

    inj_rr_arbiter #(
        .SRC_NUM (SRC_NUM)
    ) u_arb (
        .req_i       (src_req_i),
        .ptr_i       (ptr_q),
        .grant_o     (arb_grant),
        .grant_idx_o (arb_idx),
        .valid_o     (arb_valid)
    );

    assign w_len    = src_len_i[arb_idx];
    assign w_x      = src_x_dest_i[arb_idx];
    assign w_y      = src_y_dest_i[arb_idx];
    assign w_legal  = (w_len != '0) && (w_len <= LEN_W'(MAX_PKT_LEN)) &&
                      (int'(w_x) < MESH_SIZE_X) && (int'(w_y) < MESH_SIZE_Y);
    assign ptr_next = (arb_idx == PTR_W'(SRC_NUM - 1)) ? '0 : arb_idx + PTR_W'(1);
    assign vc_avail = is_allocatable_i & is_on_off_i;

    always_comb begin
        vc_found = 1'b0;
        vc_sel   = '0;
        for (int unsigned v = 0; v < VC_NUM; v++) begin
            if (!vc_found && vc_avail[v]) begin
                vc_found = 1'b1;
                vc_sel   = VC_SIZE'(v);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        src_d    = src_q;
        vc_d     = vc_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        busy_d   = 1'b0;
        err_d    = 1'b0;
        ack      = '0;
        head_lbl = HEAD;
        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    if (!w_legal) begin
                        ack   = arb_grant;
                        err_d = 1'b1;
                        ptr_d = ptr_next;
                    end else if (vc_found) begin
                        if (w_len == LEN_W'(1)) head_lbl = HEADTAIL;
                        ack     = arb_grant;
                        src_d   = arb_idx;
                        vc_d    = vc_sel;
                        cnt_d   = w_len - LEN_W'(1);
                        ptr_d   = ptr_next;
                        valid_d = 1'b1;
                        data_d  = pack_head_flit(head_lbl, vc_sel, w_x, w_y,
                                                 src_data_i[arb_idx][HEAD_PL_SIZE-1:0]);
                        if (w_len != LEN_W'(1)) begin
                            state_d = SEND;
                            busy_d  = 1'b1;
                        end
                    end
                end
            end
            SEND: begin
                // busy stays high through the cycle the TAIL sits on data_o
                busy_d = 1'b1;
                if (is_on_off_i[vc_q]) begin
                    ack[src_q]   = 1'b1;
                    valid_d      = 1'b1;
                    data_d.vc_id = vc_q;
                    data_d.data  = src_data_i[src_q];
                    cnt_d        = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        data_d.flit_label = TAIL;
                        state_d           = IDLE;
                    end else begin
                        data_d.flit_label = BODY;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            src_q   <= '0;
            vc_q    <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            src_q   <= src_d;
            vc_q    <= vc_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign src_ack_o  = ack & {SRC_NUM{rst}};
    assign data_o     = data_q;
    assign is_valid_o = valid_q;
    assign busy_o     = busy_q;
    assign err_o      = err_q;

`ifdef LOCAL_INJ_STATS_EN
    logic [SRC_NUM-1:0][15:0] pkt_cnt_q;
    logic                     tail_evt;

    // src_d names the source of the flit being registered, for both head and body paths
    assign tail_evt = valid_d &&
                      ((data_d.flit_label == TAIL) || (data_d.flit_label == HEADTAIL));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pkt_cnt_q <= '0;
        end else if (tail_evt && (pkt_cnt_q[src_d] != 16'hFFFF)) begin
            pkt_cnt_q[src_d] <= pkt_cnt_q[src_d] + 16'd1;
        end
    end

    assign pkt_cnt_o = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_local_injection_scheduler.sv
// Table-driven bench for local_injection_scheduler: one row per cycle, inputs plus expected outputs.
module tb_local_injection_scheduler;
    import noc_params::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic [3:0]           src_req_i;
    logic [3:0][1:0]      src_x_dest_i;
    logic [3:0][1:0]      src_y_dest_i;
    logic [3:0][3:0]      src_len_i;
    logic [3:0][15:0]     src_data_i;
    logic [3:0]           src_ack_o;
    flit_t                data_o;
    logic                 is_valid_o;
    logic [1:0]           is_on_off_i;
    logic [1:0]           is_allocatable_i;
    logic                 busy_o;
    logic                 err_o;
`ifdef LOCAL_INJ_STATS_EN
    logic [3:0][15:0]     pkt_cnt_o;
`endif

    local_injection_scheduler #(
        .SRC_NUM     (4),
        .MAX_PKT_LEN (8),
        .MESH_SIZE_X (2),
        .MESH_SIZE_Y (3)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .src_req_i        (src_req_i),
        .src_x_dest_i     (src_x_dest_i),
        .src_y_dest_i     (src_y_dest_i),
        .src_len_i        (src_len_i),
        .src_data_i       (src_data_i),
        .src_ack_o        (src_ack_o),
        .data_o           (data_o),
        .is_valid_o       (is_valid_o),
        .is_on_off_i      (is_on_off_i),
        .is_allocatable_i (is_allocatable_i),
        .busy_o           (busy_o),
        .err_o            (err_o)
`ifdef LOCAL_INJ_STATS_EN
        ,
        .pkt_cnt_o        (pkt_cnt_o)
`endif
    );

    typedef struct {
        string       name;
        logic        rst_n;
        logic [3:0]  req;
        logic [3:0]  len;
        logic [1:0]  x;
        logic [1:0]  y;
        logic [1:0]  alloc;
        logic [1:0]  onoff;
        logic [11:0] dat;
        logic [3:0]  e_ack;
        logic        e_valid;
        flit_label_t e_lbl;
        logic        e_vc;
        logic [15:0] e_data;
        logic        e_busy;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    function automatic void add(string nm, logic r, logic [3:0] req, logic [3:0] len,
                                logic [1:0] x, logic [1:0] y, logic [1:0] alloc,
                                logic [1:0] onoff, logic [11:0] dat, logic [3:0] ea,
                                logic ev, flit_label_t el, logic evc, logic [15:0] ed,
                                logic eb, logic ee);
        vec_t v;
        v.name = nm; v.rst_n = r; v.req = req; v.len = len; v.x = x; v.y = y;
        v.alloc = alloc; v.onoff = onoff; v.dat = dat; v.e_ack = ea; v.e_valid = ev;
        v.e_lbl = el; v.e_vc = evc; v.e_data = ed; v.e_busy = eb; v.e_err = ee;
        vecs.push_back(v);
    endfunction

    task automatic chk(string nm, string fld, logic [31:0] act, logic [31:0] exp);
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s.%s: got %0h, expected %0h", nm, fld, act, exp);
        end
    endtask

    task automatic run_rows(int lo, int hi);
        for (int i = lo; i < hi; i++) begin
            @(negedge clk);
            rst              = vecs[i].rst_n;
            src_req_i        = vecs[i].req;
            is_allocatable_i = vecs[i].alloc;
            is_on_off_i      = vecs[i].onoff;
            for (int s = 0; s < 4; s++) begin
                src_len_i[s]    = vecs[i].len;
                src_x_dest_i[s] = vecs[i].x;
                src_y_dest_i[s] = vecs[i].y;
                src_data_i[s]   = {4'(s), vecs[i].dat};
            end
            #2;
            n_vec++;
            chk(vecs[i].name, "ack",   32'(src_ack_o),  32'(vecs[i].e_ack));
            chk(vecs[i].name, "valid", 32'(is_valid_o), 32'(vecs[i].e_valid));
            chk(vecs[i].name, "busy",  32'(busy_o),     32'(vecs[i].e_busy));
            chk(vecs[i].name, "err",   32'(err_o),      32'(vecs[i].e_err));
            if (vecs[i].e_valid) begin
                chk(vecs[i].name, "label", 32'(data_o.flit_label), 32'(vecs[i].e_lbl));
                chk(vecs[i].name, "vc",    32'(data_o.vc_id),      32'(vecs[i].e_vc));
                chk(vecs[i].name, "data",  32'(data_o.data),       32'(vecs[i].e_data));
            end
        end
    endtask

`ifdef LOCAL_INJ_STATS_EN
    task automatic chk_stats(string nm, logic [15:0] c0, logic [15:0] c1,
                             logic [15:0] c2, logic [15:0] c3);
        n_vec++;
        chk(nm, "cnt0", 32'(pkt_cnt_o[0]), 32'(c0));
        chk(nm, "cnt1", 32'(pkt_cnt_o[1]), 32'(c1));
        chk(nm, "cnt2", 32'(pkt_cnt_o[2]), 32'(c2));
        chk(nm, "cnt3", 32'(pkt_cnt_o[3]), 32'(c3));
    endtask
`endif

    int mark_rst;
    int mark_a;

    initial begin
        rst = 1'b0; src_req_i = '0; src_x_dest_i = '0; src_y_dest_i = '0;
        src_len_i = '0; src_data_i = '0; is_on_off_i = '0; is_allocatable_i = '0;

        // reset held with a live request: no ack, outputs cleared
        add("rst0", 1'b0, 4'b0001, 4'd3, 2'd1, 2'd2, 2'b11, 2'b11, 12'h000, 4'b0000, 1'b0, HEAD, 1'b0, 16'h0000, 1'b0, 1'b0);
        add("rst1", 1'b0, 4'b1111, 4'd1, 2'd1, 2'd2, 2'b11, 2'b11, 12'h000, 4'b0000, 1'b0, HEAD, 1'b0, 16'h0000, 1'b0, 1'b0);
        mark_rst = vecs.size();
        // all four request single-flit packets: grants 0,1,2,3,0
        add("rr_t0", 1'b1, 4'b1111, 4'd1, 2'd1, 2'd1, 2'b01, 2'b01, 12'h200, 4'b0001, 1'b0, HEAD,     1'b0, 16'h0000, 1'b0, 1'b0);
        add("rr_t1", 1'b1, 4'b1111, 4'd1, 2'd1, 2'd1, 2'b01, 2'b01, 12'h201, 4'b0010, 1'b1, HEADTAIL, 1'b0, 16'h5200, 1'b0, 1'b0);
        add("rr_t2", 1'b1, 4'b1111, 4'd1, 2'd1, 2'd1, 2'b01, 2'b01, 12'h202, 4'b0100, 1'b1, HEADTAIL, 1'b0, 16'h5201, 1'b0, 1'b0);
        add("rr_t3", 1'b1, 4'b1111, 4'd1, 2'd1, 2'd1, 2'b01, 2'b01, 12'h203, 4'b1000, 1'b1, HEADTAIL, 1'b0, 16'h5202, 1'b0, 1'b0);
        add("rr_t4", 1'b1, 4'b1111, 4'd1, 2'd1, 2'd1, 2'b01, 2'b01, 12'h204, 4'b0001, 1'b1, HEADTAIL, 1'b0, 16'h5203, 1'b0, 1'b0);
        add("rr_t5", 1'b1, 4'b0000, 4'd1, 2'd1, 2'd1, 2'b01, 2'b01, 12'h204, 4'b0000, 1'b1, HEADTAIL, 1'b0, 16'h5204, 1'b0, 1'b0);
        add("rr_t6", 1'b1, 4'b0000, 4'd1, 2'd1, 2'd1, 2'b01, 2'b01, 12'h204, 4'b0000, 1'b0, HEAD,     1'b0, 16'h0000, 1'b0, 1'b0);
        mark_a = vecs.size();
        // src0 len 3 to (1,2); pointer is 1, so the search wraps to src0
        add("p3_t0", 1'b1, 4'b0001, 4'd3, 2'd1, 2'd2, 2'b01, 2'b01, 12'h101, 4'b0001, 1'b0, HEAD, 1'b0, 16'h0000, 1'b0, 1'b0);
        add("p3_t1", 1'b1, 4'b0001, 4'd3, 2'd1, 2'd2, 2'b01, 2'b01, 12'h102, 4'b0001, 1'b1, HEAD, 1'b0, 16'h6101, 1'b1, 1'b0);
        add("p3_t2", 1'b1, 4'b0001, 4'd3, 2'd1, 2'd2, 2'b01, 2'b01, 12'h103, 4'b0001, 1'b1, BODY, 1'b0, 16'h0102, 1'b1, 1'b0);
        add("p3_t3", 1'b1, 4'b0000, 4'd3, 2'd1, 2'd2, 2'b01, 2'b01, 12'h103, 4'b0000, 1'b1, TAIL, 1'b0, 16'h0103, 1'b1, 1'b0);
        add("p3_t4", 1'b1, 4'b0000, 4'd3, 2'd1, 2'd2, 2'b01, 2'b01, 12'h103, 4'b0000, 1'b0, HEAD, 1'b0, 16'h0000, 1'b0, 1'b0);
        // src1 len 4, VC0 switched off for two cycles mid-packet
        add("oo_t0", 1'b1, 4'b0010, 4'd4, 2'd0, 2'd1, 2'b11, 2'b11, 12'h300, 4'b0010, 1'b0, HEAD, 1'b0, 16'h0000, 1'b0, 1'b0);
        add("oo_t1", 1'b1, 4'b0010, 4'd4, 2'd0, 2'd1, 2'b11, 2'b11, 12'h301, 4'b0010, 1'b1, HEAD, 1'b0, 16'h1300, 1'b1, 1'b0);
        add("oo_t2", 1'b1, 4'b0010, 4'd4, 2'd0, 2'd1, 2'b11, 2'b10, 12'h302, 4'b0000, 1'b1, BODY, 1'b0, 16'h1301, 1'b1, 1'b0);
        add("oo_t3", 1'b1, 4'b0010, 4'd4, 2'd0, 2'd1, 2'b11, 2'b10, 12'h302, 4'b0000, 1'b0, HEAD, 1'b0, 16'h0000, 1'b1, 1'b0);
        add("oo_t4", 1'b1, 4'b0010, 4'd4, 2'd0, 2'd1, 2'b11, 2'b11, 12'h302, 4'b0010, 1'b0, HEAD, 1'b0, 16'h0000, 1'b1, 1'b0);
        add("oo_t5", 1'b1, 4'b0010, 4'd4, 2'd0, 2'd1, 2'b11, 2'b11, 12'h303, 4'b0010, 1'b1, BODY, 1'b0, 16'h1302, 1'b1, 1'b0);
        add("oo_t6", 1'b1, 4'b0000, 4'd4, 2'd0, 2'd1, 2'b11, 2'b11, 12'h303, 4'b0000, 1'b1, TAIL, 1'b0, 16'h1303, 1'b1, 1'b0);
        add("oo_t7", 1'b1, 4'b0000, 4'd4, 2'd0, 2'd1, 2'b11, 2'b11, 12'h303, 4'b0000, 1'b0, HEAD, 1'b0, 16'h0000, 1'b0, 1'b0);
        // src2 illegal descriptors: len 0, x=2, len 9, y=3
        add("il_t0", 1'b1, 4'b0100, 4'd0, 2'd0, 2'd0, 2'b01, 2'b01, 12'h400, 4'b0100, 1'b0, HEAD, 1'b0, 16'h0000, 1'b0, 1'b0);
        add("il_t1", 1'b1, 4'b0100, 4'd1, 2'd2, 2'd0, 2'b01, 2'b01, 12'h400, 4'b0100, 1'b0, HEAD, 1'b0, 16'h0000, 1'b0, 1'b1);
        add("il_t2", 1'b1, 4'b0100, 4'd9, 2'd0, 2'd0, 2'b01, 2'b01, 12'h400, 4'b0100, 1'b0, HEAD, 1'b0, 16'h0000, 1'b0, 1'b1);
        add("il_t3", 1'b1, 4'b0100, 4'd1, 2'd0, 2'd3, 2'b01, 2'b01, 12'h400, 4'b0100, 1'b0, HEAD, 1'b0, 16'h0000, 1'b0, 1'b1);
        add("il_t4", 1'b1, 4'b0000, 4'd1, 2'd0, 2'd0, 2'b01, 2'b01, 12'h400, 4'b0000, 1'b0, HEAD, 1'b0, 16'h0000, 1'b0, 1'b1);
        add("il_t5", 1'b1, 4'b0000, 4'd1, 2'd0, 2'd0, 2'b01, 2'b01, 12'h400, 4'b0000, 1'b0, HEAD, 1'b0, 16'h0000, 1'b0, 1'b0);
        // src3 waits for a VC that is both allocatable and on, then gets VC1
        add("va_t0", 1'b1, 4'b1000, 4'd2, 2'd1, 2'd0, 2'b00, 2'b11, 12'h500, 4'b0000, 1'b0, HEAD, 1'b0, 16'h0000, 1'b0, 1'b0);
        add("va_t1", 1'b1, 4'b1000, 4'd2, 2'd1, 2'd0, 2'b11, 2'b00, 12'h500, 4'b0000, 1'b0, HEAD, 1'b0, 16'h0000, 1'b0, 1'b0);
        add("va_t2", 1'b1, 4'b1000, 4'd2, 2'd1, 2'd0, 2'b10, 2'b11, 12'h500, 4'b1000, 1'b0, HEAD, 1'b0, 16'h0000, 1'b0, 1'b0);
        add("va_t3", 1'b1, 4'b1000, 4'd2, 2'd1, 2'd0, 2'b10, 2'b11, 12'h501, 4'b1000, 1'b1, HEAD, 1'b1, 16'h4500, 1'b1, 1'b0);
        add("va_t4", 1'b1, 4'b0000, 4'd2, 2'd1, 2'd0, 2'b10, 2'b11, 12'h501, 4'b0000, 1'b1, TAIL, 1'b1, 16'h3501, 1'b1, 1'b0);
        add("va_t5", 1'b1, 4'b0000, 4'd2, 2'd1, 2'd0, 2'b10, 2'b11, 12'h501, 4'b0000, 1'b0, HEAD, 1'b0, 16'h0000, 1'b0, 1'b0);
        // reset after the HEAD of a len-5 packet, then pointer must be back at 0
        add("rs_t0", 1'b1, 4'b0001, 4'd5, 2'd1, 2'd2, 2'b01, 2'b01, 12'h600, 4'b0001, 1'b0, HEAD,     1'b0, 16'h0000, 1'b0, 1'b0);
        add("rs_t1", 1'b1, 4'b0001, 4'd5, 2'd1, 2'd2, 2'b01, 2'b01, 12'h601, 4'b0001, 1'b1, HEAD,     1'b0, 16'h6600, 1'b1, 1'b0);
        add("rs_t2", 1'b0, 4'b0001, 4'd5, 2'd1, 2'd2, 2'b01, 2'b01, 12'h602, 4'b0000, 1'b0, HEAD,     1'b0, 16'h0000, 1'b0, 1'b0);
        add("rs_t3", 1'b1, 4'b0000, 4'd5, 2'd1, 2'd2, 2'b01, 2'b01, 12'h602, 4'b0000, 1'b0, HEAD,     1'b0, 16'h0000, 1'b0, 1'b0);
        add("rs_t4", 1'b1, 4'b0011, 4'd1, 2'd0, 2'd0, 2'b01, 2'b01, 12'h700, 4'b0001, 1'b0, HEAD,     1'b0, 16'h0000, 1'b0, 1'b0);
        add("rs_t5", 1'b1, 4'b0000, 4'd1, 2'd0, 2'd0, 2'b01, 2'b01, 12'h700, 4'b0000, 1'b1, HEADTAIL, 1'b0, 16'h0700, 1'b0, 1'b0);
        add("rs_t6", 1'b1, 4'b0000, 4'd1, 2'd0, 2'd0, 2'b01, 2'b01, 12'h700, 4'b0000, 1'b0, HEAD,     1'b0, 16'h0000, 1'b0, 1'b0);

        run_rows(0, mark_rst);
`ifdef LOCAL_INJ_STATS_EN
        chk_stats("stats_reset", 16'd0, 16'd0, 16'd0, 16'd0);
`endif
        run_rows(mark_rst, mark_a);
`ifdef LOCAL_INJ_STATS_EN
        chk_stats("stats_rr", 16'd2, 16'd1, 16'd1, 16'd1);
`endif
        run_rows(mark_a, vecs.size());
`ifdef LOCAL_INJ_STATS_EN
        chk_stats("stats_end", 16'd1, 16'd0, 16'd0, 16'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
